// File: rtl/round_scheduler.sv
// round_scheduler: round sequencer for a reaction game.
// Waits a pseudo-random delay, lights one random target LED for a level-dependent
// window, reports hit_ack or miss, and ends the game when the seconds counter expires.
// Optional feature: define ROUND_SCHED_PAUSE_EN to add a pause input that freezes
// every timer (prescaler, delay, window, seconds) and ignores hit while asserted.
module round_scheduler #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int LED_NUM        = 18,
  parameter int GAME_SECONDS   = 60,
  parameter int MIN_DELAY_MS   = 500,
  parameter int MAX_DELAY_MS   = 2047,
  parameter int BASE_WINDOW_MS = 1000,
  parameter int MIN_WINDOW_MS  = 200
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              hit,
  input  logic [3:0]                        level,
`ifdef ROUND_SCHED_PAUSE_EN
  input  logic                              pause,
`endif
  output logic                              led_on,
  output logic [$clog2(LED_NUM)-1:0]        led_index,
  output logic [$clog2(GAME_SECONDS+1)-1:0] seconds_left,
  output logic                              hit_ack,
  output logic                              miss,
  output logic                              game_over
);

  localparam int DIV    = CLK_HZ / 1000;
  localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW     = $clog2(MAX_DELAY_MS + 1);
  localparam int WMAX   = (BASE_WINDOW_MS > MIN_WINDOW_MS) ? BASE_WINDOW_MS : MIN_WINDOW_MS;
  localparam int WW     = $clog2(WMAX + 1);
  localparam int LW     = $clog2(LED_NUM);
  localparam int SW     = $clog2(GAME_SECONDS + 1);
  localparam int DRANGE = MAX_DELAY_MS - MIN_DELAY_MS + 1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE, DELAY, WINDOW, DONE} state_t;

  state_t             state;
  logic [PW-1:0]      presc;
  logic [9:0]         ms_cnt;
  logic [DW-1:0]      delay_cnt;
  logic [WW-1:0]      window_cnt;
  logic [15:0]        lfsr;

  logic               paused;
  logic               running;
  logic               ms_tick;
  logic               hit_eff;
  logic               sec_expire;
  logic [15:0]        lfsr_next;
  logic [DW-1:0]      delay_load;
  logic signed [15:0] win_raw;
  logic [WW-1:0]      window_load;
  logic [LW-1:0]      led_pick;

`ifdef ROUND_SCHED_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  // Timers only advance while a game is in progress and not frozen.
  assign running    = ((state == DELAY) || (state == WINDOW)) && !paused;
  assign ms_tick    = running && (presc == PW'(DIV - 1));
  assign hit_eff    = hit && !paused;
  assign sec_expire = ms_tick && (ms_cnt == 10'd999) && (seconds_left == SW'(1));

  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1.
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  // Random pre-target delay and target LED derived from the current LFSR state.
  assign delay_load = DW'(32'(MIN_DELAY_MS) + ({16'd0, lfsr} % 32'(DRANGE)));
  assign led_pick   = LW'({16'd0, lfsr} % 32'(LED_NUM));

  // Window shrinks by 200 ms per level; signed math lets high levels go negative before clamping.
  assign win_raw     = $signed(16'(BASE_WINDOW_MS)) - $signed({12'd0, level}) * 16'sd200;
  assign window_load = (win_raw < $signed(16'(MIN_WINDOW_MS))) ? WW'(MIN_WINDOW_MS) : WW'(win_raw);

  // Round FSM with all timers and registered outputs; priority is expiry > start > hit > window end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      presc        <= '0;
      ms_cnt       <= '0;
      delay_cnt    <= '0;
      window_cnt   <= '0;
      lfsr         <= LFSR_SEED;
      led_on       <= 1'b0;
      led_index    <= '0;
      seconds_left <= '0;
      hit_ack      <= 1'b0;
      miss         <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      lfsr    <= lfsr_next;
      hit_ack <= 1'b0;
      miss    <= 1'b0;

      if (running) begin
        presc <= (presc == PW'(DIV - 1)) ? '0 : presc + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state        <= DELAY;
            seconds_left <= SW'(GAME_SECONDS);
            delay_cnt    <= delay_load;
            presc        <= '0;
            ms_cnt       <= '0;
            led_on       <= 1'b0;
            game_over    <= 1'b0;
          end
        end

        DELAY, WINDOW: begin
          if (sec_expire) begin
            state        <= DONE;
            seconds_left <= '0;
            led_on       <= 1'b0;
            game_over    <= 1'b1;
          end else if (start) begin
            state  <= IDLE;
            led_on <= 1'b0;
          end else begin
            if (ms_tick) begin
              if (ms_cnt == 10'd999) begin
                ms_cnt       <= '0;
                seconds_left <= seconds_left - 1'b1;
              end else begin
                ms_cnt <= ms_cnt + 1'b1;
              end
            end

            if (state == DELAY) begin
              if (ms_tick) begin
                if (delay_cnt <= DW'(1)) begin
                  state      <= WINDOW;
                  led_on     <= 1'b1;
                  led_index  <= led_pick;
                  window_cnt <= window_load;
                end else begin
                  delay_cnt <= delay_cnt - 1'b1;
                end
              end
            end else begin
              if (hit_eff) begin
                state     <= DELAY;
                hit_ack   <= 1'b1;
                led_on    <= 1'b0;
                delay_cnt <= delay_load;
              end else if (ms_tick) begin
                if (window_cnt <= WW'(1)) begin
                  state     <= DELAY;
                  miss      <= 1'b1;
                  led_on    <= 1'b0;
                  delay_cnt <= delay_load;
                end else begin
                  window_cnt <= window_cnt - 1'b1;
                end
              end
            end
          end
        end

        DONE: begin
          if (start) begin
            state     <= IDLE;
            game_over <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_scheduler.sv
// tb_round_scheduler: randomized bench for round_scheduler with a timeline reference model.
// The model tracks elapsed game milliseconds and the start of the current round, and
// derives LED / pulse / seconds expectations from the delay and window lengths.
// Define ROUND_SCHED_PAUSE_EN to also exercise the pause input.
module tb_round_scheduler;

  localparam int GS   = 2;
  localparam int LEDN = 18;
  localparam int BASE = 1000;
  localparam int MINW = 200;
  localparam int DLY  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic [3:0] level = 4'd0;
  logic       pause = 1'b0;
  logic       led_on;
  logic [4:0] led_index;
  logic [1:0] seconds_left;
  logic       hit_ack;
  logic       miss;
  logic       game_over;

  round_scheduler #(
    .CLK_HZ        (1000),
    .LED_NUM       (LEDN),
    .GAME_SECONDS  (GS),
    .MIN_DELAY_MS  (DLY),
    .MAX_DELAY_MS  (DLY),
    .BASE_WINDOW_MS(BASE),
    .MIN_WINDOW_MS (MINW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .hit         (hit),
    .level       (level),
`ifdef ROUND_SCHED_PAUSE_EN
    .pause       (pause),
`endif
    .led_on      (led_on),
    .led_index   (led_index),
    .seconds_left(seconds_left),
    .hit_ack     (hit_ack),
    .miss        (miss),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 = idle, 1 = playing, 2 = game over.
  int mstate = 0;
  int e = 0;          // game milliseconds elapsed
  int seg = 0;        // elapsed time at which the current delay began
  int win_len = 0;
  int hit_at = -1;    // window cycle on which the bench will hit, -1 = never
  int pause_left = 0;
  bit quiet = 1'b0;
  bit exp_led = 1'b0;
  bit exp_ack = 1'b0;
  bit exp_miss = 1'b0;
  bit exp_over = 1'b0;
  int exp_sec = 0;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic int win_of(input int lv);
    int w;
    w = BASE - 200 * lv;
    return (w < MINW) ? MINW : w;
  endfunction

  task automatic model_reset();
    mstate = 0; e = 0; seg = 0; hit_at = -1; pause_left = 0;
    exp_led = 0; exp_ack = 0; exp_miss = 0; exp_over = 0; exp_sec = 0;
  endtask

  // Advance the model by one clock edge using the inputs held during the past cycle.
  task automatic model_edge(input bit st, input bit ht, input int lv, input bit ps);
    exp_ack = 0;
    exp_miss = 0;
    case (mstate)
      0: if (st) begin
        mstate = 1; e = 0; seg = 0; exp_sec = GS; exp_led = 0;
      end
      1: begin
        if (!ps) e++;
        if (!ps && e == GS * 1000) begin
          mstate = 2; exp_led = 0; exp_over = 1; exp_sec = 0;
        end else if (st) begin
          mstate = 0; exp_led = 0;
        end else if (!ps) begin
          exp_sec = GS - e / 1000;
          if (exp_led) begin
            if (ht) begin
              exp_ack = 1; exp_led = 0; seg = e;
            end else if (e - seg == DLY + win_len) begin
              exp_miss = 1; exp_led = 0; seg = e;
            end
          end else if (e - seg == DLY) begin
            exp_led = 1;
            win_len = win_of(lv);
            hit_at = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 40));
          end
        end
      end
      default: if (st) begin
        mstate = 0; exp_over = 0;
      end
    endcase
  endtask

  // Choose the inputs for the next cycle (called just after the falling edge).
  task automatic drive();
    start = 1'b0;
    hit = 1'b0;
    level = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    if (quiet) begin
      start = (mstate != 1);
    end else begin
      case (mstate)
        0: start = ($urandom_range(0, 7) == 0);
        2: start = ($urandom_range(0, 15) == 0);
        default: begin
          if (exp_led) begin
            if (e - seg - DLY == hit_at) begin
              hit = 1'b1;
              start = ($urandom_range(0, 3) == 0);
            end
          end else begin
            hit = ($urandom_range(0, 9) == 0);
          end
          if ($urandom_range(0, 2499) == 0) start = 1'b1;
        end
      endcase
    end
`ifdef ROUND_SCHED_PAUSE_EN
    if (pause_left > 0) begin
      pause = 1'b1;
      pause_left--;
    end else begin
      pause = 1'b0;
      if (exp_led && !quiet && $urandom_range(0, 99) == 0) pause_left = $urandom_range(1, 60);
    end
`else
    pause = 1'b0;
`endif
  endtask

  task automatic compare();
    check("led_on", int'(led_on), int'(exp_led));
    check("hit_ack", int'(hit_ack), int'(exp_ack));
    check("miss", int'(miss), int'(exp_miss));
    check("game_over", int'(game_over), int'(exp_over));
    check("seconds_left", int'(seconds_left), exp_sec);
    check("ack_miss_exclusive", int'(hit_ack & miss), 0);
    if (exp_led) check("led_index_range", int'(led_index < 5'(LEDN)), 1);
    if (exp_ack)  $display("[%0t] round: hit_ack  elapsed=%0d sec=%0d", $time, e, seconds_left);
    if (exp_miss) $display("[%0t] round: miss     elapsed=%0d win=%0d", $time, e, win_len);
  endtask

  task automatic step();
    bit prev_over;
    int prev_state;
    prev_over = exp_over;
    prev_state = mstate;
    @(posedge clk);
    model_edge(start, hit, int'(level), pause);
    @(negedge clk);
    compare();
    if (prev_state != 1 && mstate == 1) $display("[%0t] game: start", $time);
    if (prev_state == 1 && mstate == 0) $display("[%0t] game: abort at elapsed=%0d", $time, e);
    if (!prev_over && exp_over) $display("[%0t] game: over", $time);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led_on"}, int'(led_on), 0);
    check({tag, "_led_index"}, int'(led_index), 0);
    check({tag, "_seconds_left"}, int'(seconds_left), 0);
    check({tag, "_hit_ack"}, int'(hit_ack), 0);
    check({tag, "_miss"}, int'(miss), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int c = 0; c < 14000; c++) begin
      drive();
      step();
    end

    // Steer into a target window, then pull reset asynchronously between edges.
    quiet = 1'b1;
    for (int c = 0; c < 3000 && !(mstate == 1 && exp_led); c++) begin
      drive();
      step();
    end
    check("reach_window", int'(led_on), 1);
    start = 1'b0;
    hit = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    model_reset();
    check_all_zero("held_reset");
    rst_n = 1'b1;
    quiet = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      drive();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
